// File: rtl/piso_sched.sv
// Two-requester round-robin parallel-in/serial-out frame scheduler.
// Frames go out LSB first, each bit held DIV cycles, followed by GAP idle cycles.
module piso_sched #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             so,
    output logic             so_valid,
    output logic             sof,
    output logic             src_id,
    output logic             busy
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state_q;
    logic             rr_q;
    logic [WIDTH-1:0] sreg_q;
    logic [BW-1:0]    bit_cnt_q;
    logic [DW-1:0]    div_cnt_q;
    logic [GW-1:0]    gap_cnt_q;
    logic             so_q;
    logic             so_valid_q;
    logic             sof_q;
    logic             src_q;
    logic             busy_q;

    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] word_sel;

    // rst_n gates the grants so ready is low throughout reset, even in IDLE.
    always_comb begin
        grant0   = rst_n && (state_q == S_IDLE) && req0_valid && (!req1_valid || !rr_q);
        grant1   = rst_n && (state_q == S_IDLE) && req1_valid && (!req0_valid || rr_q);
        word_sel = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign so         = so_q;
    assign so_valid   = so_valid_q;
    assign sof        = sof_q;
    assign src_id     = src_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            so_q       <= 1'b0;
            so_valid_q <= 1'b0;
            sof_q      <= 1'b0;
            src_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        sreg_q     <= word_sel;
                        src_q      <= grant1;
                        rr_q       <= !grant1;
                        bit_cnt_q  <= BIT_LAST;
                        div_cnt_q  <= DIV_LAST;
                        so_q       <= word_sel[0];
                        so_valid_q <= 1'b1;
                        sof_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sof_q <= 1'b0;
                    if (div_cnt_q != '0) begin
                        div_cnt_q <= div_cnt_q - 1'b1;
                    end else if (bit_cnt_q != '0) begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                        div_cnt_q <= DIV_LAST;
                        sreg_q    <= {1'b0, sreg_q[WIDTH-1:1]};
                        so_q      <= sreg_q[1];
                    end else begin
                        // Last cycle of the final bit: leave SHIFT.
                        sreg_q     <= '0;
                        so_q       <= 1'b0;
                        so_valid_q <= 1'b0;
                        if (GAP == 0) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            gap_cnt_q <= GAP_LAST;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
